// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: address-map decode, store lane steering,
// a one-cycle stage register for loads, and the MMIO cycle/instret counters.
module mem_stage_lsu #(
    parameter int DMEM_AW = 14,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               req_valid,
    input  logic               req_load,
    input  logic               req_store,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    input  logic               retire,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [3:0]         dmem_we,
    output logic [31:0]        dmem_din,
    input  logic [31:0]        dmem_dout,
    output logic [DMEM_AW-1:0] imem_addr,
    output logic [3:0]         imem_we,
    output logic [31:0]        imem_din,
    output logic               wb_valid,
    output logic [31:0]        wb_rdata,
    output logic               misalign
);

    localparam logic [31:0] MMIO_CYCLE   = 32'h8000_0010;
    localparam logic [31:0] MMIO_INSTRET = 32'h8000_0014;
    localparam logic [31:0] MMIO_CLEAR   = 32'h8000_0018;

    logic             fire;
    logic             is_load;
    logic             is_mem;
    logic             misaligned;
    logic             store_go;
    logic             clear_cnt;
    logic             in_dmem;
    logic             in_imem;
    logic [3:0]       lane_we;
    logic [31:0]      lane_din;
    logic [31:0]      mmio_rdata;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;

    logic             s_load;
    logic             s_mis;
    logic [2:0]       s_funct3;
    logic [1:0]       s_off;
    logic [3:0]       s_region;
    logic [31:0]      s_snap;
    logic [31:0]      load_word;
    logic [31:0]      lane_word;

    // Request decode; a store beats a load if both are flagged.
    always_comb begin
        fire       = req_valid & ~stall & ~rst;
        is_load    = req_load & ~req_store;
        is_mem     = req_load | req_store;
        in_dmem    = (req_addr[31:28] == 4'h1) || (req_addr[31:28] == 4'h3);
        in_imem    = (req_addr[31:28] == 4'h2) || (req_addr[31:28] == 4'h3);
        misaligned = 1'b0;
        lane_we    = 4'b0000;
        lane_din   = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                lane_we  = 4'b0001 << req_addr[1:0];
                lane_din = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = req_addr[0];
                lane_we    = req_addr[1] ? 4'b1100 : 4'b0011;
                lane_din   = {2{req_wdata[15:0]}};
            end
            default: begin
                misaligned = |req_addr[1:0];
                lane_we    = 4'b1111;
                lane_din   = req_wdata;
            end
        endcase
        misaligned = misaligned & is_mem;
        store_go   = fire & req_store & ~misaligned;
        clear_cnt  = store_go & (req_addr == MMIO_CLEAR);
        mmio_rdata = 32'h0;
        if (req_addr == MMIO_CYCLE) begin
            mmio_rdata = 32'(cycle_cnt);
        end else if (req_addr == MMIO_INSTRET) begin
            mmio_rdata = 32'(instret_cnt);
        end
    end

    assign dmem_addr = req_addr[DMEM_AW+1:2];
    assign imem_addr = req_addr[DMEM_AW+1:2];
    assign dmem_din  = lane_din;
    assign imem_din  = lane_din;
    assign dmem_we   = (store_go & in_dmem) ? lane_we : 4'b0000;
    assign imem_we   = (store_go & in_imem) ? lane_we : 4'b0000;

    // A clear store wins over the increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clear_cnt) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt   <= cycle_cnt + 1'b1;
            instret_cnt <= instret_cnt + CNT_W'(retire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_load   <= 1'b0;
            s_mis    <= 1'b0;
            s_funct3 <= 3'b000;
            s_off    <= 2'b00;
            s_region <= 4'h0;
            s_snap   <= 32'h0;
            misalign <= 1'b0;
        end else begin
            misalign <= fire & misaligned;
            if (fire) begin
                s_load   <= is_load;
                s_mis    <= misaligned;
                s_funct3 <= req_funct3;
                s_off    <= req_addr[1:0];
                s_region <= req_addr[31:28];
                s_snap   <= mmio_rdata;
            end else if (!stall) begin
                s_load   <= 1'b0;
                s_mis    <= 1'b0;
                s_funct3 <= 3'b000;
                s_off    <= 2'b00;
                s_region <= 4'h0;
                s_snap   <= 32'h0;
            end
        end
    end

    // Lane select and extension of the returning word; stays stable under stall.
    always_comb begin
        load_word = 32'h0;
        if (!s_mis) begin
            if (s_region == 4'h1 || s_region == 4'h3) begin
                load_word = dmem_dout;
            end else if (s_region == 4'h8) begin
                load_word = s_snap;
            end
        end
        lane_word = load_word >> {s_off, 3'b000};
        case (s_funct3)
            3'b000:  wb_rdata = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b001:  wb_rdata = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b100:  wb_rdata = {24'h0, lane_word[7:0]};
            3'b101:  wb_rdata = {16'h0, lane_word[15:0]};
            default: wb_rdata = load_word;
        endcase
        if (!s_load) begin
            wb_rdata = 32'h0;
        end
    end

    assign wb_valid = s_load;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: a byte-level reference memory and counter
// model predict every response; a monitor checks what the DUT returns.
module tb_mem_stage_lsu;

    localparam int DMEM_AW = 14;

    logic               clk = 1'b0;
    logic               rst, stall, req_valid, req_load, req_store, retire;
    logic [2:0]         req_funct3;
    logic [31:0]        req_addr, req_wdata;
    logic [DMEM_AW-1:0] dmem_addr, imem_addr;
    logic [3:0]         dmem_we, imem_we;
    logic [31:0]        dmem_din, imem_din, dmem_dout, wb_rdata;
    logic               wb_valid, misalign;

    always #5 clk = ~clk;

    mem_stage_lsu #(.DMEM_AW(DMEM_AW), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .req_valid(req_valid),
        .req_load(req_load), .req_store(req_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .retire(retire),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_din(dmem_din),
        .dmem_dout(dmem_dout), .imem_addr(imem_addr), .imem_we(imem_we),
        .imem_din(imem_din), .wb_valid(wb_valid), .wb_rdata(wb_rdata),
        .misalign(misalign)
    );

    // Synchronous-read DMEM; the read port holds its output while the stage is stalled.
    logic [31:0] dmem_array [0:(1<<DMEM_AW)-1] = '{default: '0};
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (dmem_we[b]) dmem_array[dmem_addr][8*b +: 8] <= dmem_din[8*b +: 8];
        end
        if (!stall) dmem_dout <= dmem_array[dmem_addr];
    end

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    bit [7:0]    ref_mem [int];
    logic [31:0] ref_cycle = 0, ref_instret = 0;
    logic        cur_fire_mis = 0, mis_exp = 0, prev_stall = 0, prev_rst = 1;
    logic        mon_en = 0, last_valid = 0;
    logic [31:0] last_data = 0;
    int          edge_cnt = 0;
    int          n_checks = 0, n_errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int accessBytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [7:0] refByte(input int key);
        return ref_mem.exists(key) ? ref_mem[key] : 8'h00;
    endfunction

    // Expected load result from the byte-addressed memory and counter model.
    function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] a);
        int          nb;
        logic [31:0] w, val;
        nb  = accessBytes(f3);
        val = 32'h0;
        w   = 32'h0;
        if (a[31:28] == 4'h1 || a[31:28] == 4'h3) begin
            for (int i = 0; i < nb; i++) val[8*i +: 8] = refByte(int'(a[15:0]) + i);
        end else if (a[31:28] == 4'h8) begin
            if (a == 32'h8000_0010) w = ref_cycle;
            else if (a == 32'h8000_0014) w = ref_instret;
            for (int i = 0; i < nb; i++) val[8*i +: 8] = w[8*i +: 8];
        end
        if (nb == 1 && !f3[2]) val = {{24{val[7]}}, val[7:0]};
        if (nb == 2 && !f3[2]) val = {{16{val[15]}}, val[15:0]};
        return val;
    endfunction

    task automatic applyStimulus(input logic v, input logic ld, input logic st,
                                 input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic stl,
                                 input logic ret, input logic rs);
        logic        fire, mis, dm, im, clr;
        logic [3:0]  mask, e_dwe, e_iwe;
        logic [31:0] e_din;
        exp_t        e;
        int          nb;
        req_valid = v; req_load = ld; req_store = st; req_funct3 = f3;
        req_addr = a; req_wdata = wd; stall = stl; retire = ret; rst = rs;
        #2;
        nb   = accessBytes(f3);
        fire = v && !stl && !rs;
        mis  = (ld || st) && ((int'(a[1:0]) % nb) != 0);
        dm   = (a[31:28] == 4'h1) || (a[31:28] == 4'h3);
        im   = (a[31:28] == 4'h2) || (a[31:28] == 4'h3);
        mask = 4'b0000;
        for (int i = 0; i < nb; i++) mask[(int'(a[1:0]) + i) % 4] = 1'b1;
        e_dwe = (fire && st && !mis && dm) ? mask : 4'b0000;
        e_iwe = (fire && st && !mis && im) ? mask : 4'b0000;
        e_din = (nb == 1) ? {4{wd[7:0]}} : (nb == 2) ? {2{wd[15:0]}} : wd;
        checkOutput("dmem_we", 32'(dmem_we), 32'(e_dwe));
        checkOutput("imem_we", 32'(imem_we), 32'(e_iwe));
        if (v && st) begin
            checkOutput("dmem_din", dmem_din, e_din);
            checkOutput("imem_din", imem_din, e_din);
        end
        if (v) begin
            checkOutput("dmem_addr", 32'(dmem_addr), 32'(a[15:2]));
            checkOutput("imem_addr", 32'(imem_addr), 32'(a[15:2]));
        end
        cur_fire_mis = fire && mis;
        if (fire && ld && !st) begin
            e.data = mis ? 32'h0 : refLoad(f3, a);
            e.due  = edge_cnt + 1;
            exp_q.push_back(e);
        end
        clr = fire && st && !mis && (a == 32'h8000_0018);
        @(posedge clk);
        if (rs || clr) begin
            ref_cycle   = 0;
            ref_instret = 0;
        end else begin
            ref_cycle   = ref_cycle + 1;
            ref_instret = ref_instret + 32'(ret);
        end
        if (fire && st && !mis && dm) begin
            for (int i = 0; i < nb; i++) ref_mem[int'(a[15:0]) + i] = wd[8*i +: 8];
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic ret);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, ret, 1'b0);
    endtask

    always @(posedge clk) begin
        prev_stall <= stall;
        prev_rst   <= rst;
        mis_exp    <= cur_fire_mis;
        edge_cnt   <= edge_cnt + 1;
    end

    // Monitor: match each response to its scheduled cycle; under stall it must hold.
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("misalign", 32'(misalign), 32'(mis_exp));
            if (prev_stall && !prev_rst && last_valid) begin
                checkOutput("wb_valid_hold", 32'(wb_valid), 32'h1);
                checkOutput("wb_rdata_hold", wb_rdata, last_data);
            end else if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("wb_valid", 32'(wb_valid), 32'h1);
                checkOutput("wb_rdata", wb_rdata, e.data);
                last_data = e.data;
            end else begin
                checkOutput("wb_valid_idle", 32'(wb_valid), 32'h0);
            end
            last_valid = (wb_valid === 1'b1);
        end
    end

    initial begin
        logic [3:0]  rg;
        logic [31:0] a;
        logic        st;
        logic [2:0]  f3;
        int          k;
        rst = 1'b1; stall = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0; retire = 1'b0;
        @(negedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 32'h1000_0000, 32'h5555_5555, 1'b0, 1'b0, 1'b1);
        checkOutput("reset_wb_valid", 32'(wb_valid), 32'h0);
        checkOutput("reset_wb_rdata", wb_rdata, 32'h0);
        checkOutput("reset_misalign", 32'(misalign), 32'h0);
        mon_en = 1'b1;

        $display("[TB] directed sequence");
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h1000_0004, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b000, 32'h1000_0003, 32'h0000_0080, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 32'h1000_0003, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b100, 32'h1000_0003, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b001, 32'h3000_0002, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b001, 32'h2000_0002, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b001, 32'h1000_0002, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h1000_0002, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b001, 32'h1000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        idle(1'b0);

        for (int i = 0; i < 100; i++) idle(1'((i % 2) == 0));
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h8000_0014, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 32'h8000_0018, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h8000_0014, 32'h0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 32'h1000_0008, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 32'h1000_0008, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h1000_0004, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h1000_0008, 32'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h1000_0008, 32'h0, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b1, 3'b010, 32'h1000_000C, 32'h1122_3344, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h1000_000C, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h1000_0004, 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 32'h1000_0004, 32'h0BAD_0BAD, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h1000_0004, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("[TB] random sequence");
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 5);
            case (k)
                0:       rg = 4'h1;
                1:       rg = 4'h3;
                2:       rg = 4'h2;
                3:       rg = 4'h8;
                4:       rg = 4'h0;
                default: rg = 4'hF;
            endcase
            st = 1'($urandom_range(0, 1));
            if (st) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                k  = $urandom_range(0, 4);
                f3 = (k < 3) ? 3'(k) : 3'(k + 1);
            end
            if (rg == 4'h8)
                a = 32'h8000_0010 + 32'(4 * $urandom_range(0, 3))
                    + (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            else
                a = {rg, 22'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            applyStimulus(1'($urandom_range(0, 7) != 0), !st, st, f3, a, $urandom,
                          1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 99) == 0));
        end

        for (int i = 0; i < 3; i++) idle(1'b0);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
